// File: rtl/idelay_tap_scan_pkg.sv
// Shared types and constants for the input-delay tap scanner and its run tracker.
package idelay_tap_scan_pkg;

   localparam int TAP_W = 5;
   localparam int NTAPS = 32;
   localparam int EYE_W = 6;

   typedef logic [TAP_W-1:0] tap_t;
   typedef logic [EYE_W-1:0] eye_t;
   typedef logic [2:0]       state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LOAD    = 3'd1;
   localparam state_t ST_SETTLE  = 3'd2;
   localparam state_t ST_MEASURE = 3'd3;
   localparam state_t ST_NEXT    = 3'd4;
   localparam state_t ST_CENTER  = 3'd5;
   localparam state_t ST_APPLY   = 3'd6;
   localparam state_t ST_DONE    = 3'd7;

   // Floor of the window midpoint; start + (len-1)/2 never exceeds the last tap.
   function automatic tap_t center_tap(input tap_t start, input eye_t len);
      eye_t half;
      half = (len - 6'd1) >> 1;
      return start + half[TAP_W-1:0];
   endfunction

endpackage

// File: rtl/idelay_tap_scan_run_tracker.sv
// Tracks the current and best contiguous run of passing taps and the best window centre.
module idelay_run_tracker
   import idelay_tap_scan_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_step,
   input  logic             i_pass,
   input  logic [TAP_W-1:0] i_tap,
   output logic [EYE_W-1:0] o_best_len,
   output logic [TAP_W-1:0] o_best_start,
   output logic [TAP_W-1:0] o_center
);

   logic [EYE_W-1:0] r_cur_len;
   logic [TAP_W-1:0] r_cur_start;
   logic [EYE_W-1:0] r_best_len;
   logic [TAP_W-1:0] r_best_start;
   logic [EYE_W-1:0] w_new_len;
   logic [TAP_W-1:0] w_new_start;

   always_comb begin
      w_new_len = r_cur_len + 6'd1;
      if (r_cur_len == 6'd0) begin
         w_new_start = i_tap;
      end else begin
         w_new_start = r_cur_start;
      end
   end

   // Strictly-greater update keeps the earliest of equal-length windows.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cur_len    <= 6'd0;
         r_cur_start  <= 5'd0;
         r_best_len   <= 6'd0;
         r_best_start <= 5'd0;
      end else if (i_clr) begin
         r_cur_len    <= 6'd0;
         r_cur_start  <= 5'd0;
         r_best_len   <= 6'd0;
         r_best_start <= 5'd0;
      end else if (i_step) begin
         if (i_pass) begin
            r_cur_len   <= w_new_len;
            r_cur_start <= w_new_start;
            if (w_new_len > r_best_len) begin
               r_best_len   <= w_new_len;
               r_best_start <= w_new_start;
            end
         end else begin
            r_cur_len <= 6'd0;
         end
      end
   end

   assign o_best_len   = r_best_len;
   assign o_best_start = r_best_start;
   assign o_center     = center_tap(r_best_start, r_best_len);

endmodule

// File: rtl/idelay_tap_scan.sv
// Sweeps all delay taps, scores each with checker verdicts and loads the centre of the widest passing eye.
module idelay_tap_scan
   import idelay_tap_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16,
   parameter int SAMPLES       = 64,
   parameter int DEFAULT_TAP   = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic             i_host_ld,
   input  logic [TAP_W-1:0] i_host_val,
   output logic             o_tap_ld,
   output logic [TAP_W-1:0] o_tap_val,
   input  logic [TAP_W-1:0] i_tap_readback,
   input  logic             i_sample_valid,
   input  logic             i_sample_ok,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_fail,
   output logic             o_err,
   output logic [TAP_W-1:0] o_best_tap,
   output logic [EYE_W-1:0] o_eye_width
);

   localparam logic [15:0]      SETTLE_INIT = 16'(SETTLE_CYCLES);
   localparam logic [15:0]      SAMP_LAST   = 16'(SAMPLES - 1);
   localparam logic [TAP_W-1:0] DEF_TAP     = TAP_W'(DEFAULT_TAP);
   localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NTAPS - 1);

   state_t           r_state;
   logic [TAP_W-1:0] r_tap;
   logic             r_tap_ld;
   logic [TAP_W-1:0] r_tap_val;
   logic [15:0]      r_settle;
   logic [15:0]      r_samp;
   logic             r_pass;
   logic             r_busy;
   logic             r_done;
   logic             r_fail;
   logic             r_err;
   logic [TAP_W-1:0] r_best_tap;
   logic [EYE_W-1:0] r_eye;

   logic             w_clr;
   logic             w_step;
   logic [EYE_W-1:0] w_best_len;
   logic [TAP_W-1:0] w_best_start;
   logic [TAP_W-1:0] w_center;

   assign w_clr  = (r_state == ST_IDLE) && i_start;
   assign w_step = (r_state == ST_NEXT);

   idelay_run_tracker u_tracker (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_clr        (w_clr),
      .i_step       (w_step),
      .i_pass       (r_pass),
      .i_tap        (r_tap),
      .o_best_len   (w_best_len),
      .o_best_start (w_best_start),
      .o_center     (w_center)
   );

   // Scan sequencer; strobes default low and are raised only in the state that owns them.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_tap      <= 5'd0;
         r_tap_ld   <= 1'b0;
         r_tap_val  <= DEF_TAP;
         r_settle   <= 16'd0;
         r_samp     <= 16'd0;
         r_pass     <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_fail     <= 1'b0;
         r_err      <= 1'b0;
         r_best_tap <= 5'd0;
         r_eye      <= 6'd0;
      end else begin
         r_tap_ld <= 1'b0;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_fail  <= 1'b0;
                  r_err   <= 1'b0;
                  r_tap   <= 5'd0;
                  r_busy  <= 1'b1;
                  r_state <= ST_LOAD;
               end else if (i_host_ld) begin
                  r_tap_ld  <= 1'b1;
                  r_tap_val <= i_host_val;
               end
            end
            ST_LOAD: begin
               r_tap_ld  <= 1'b1;
               r_tap_val <= r_tap;
               r_settle  <= SETTLE_INIT;
               r_state   <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (r_settle <= 16'd1) begin
                  // A readback mismatch flags the error and fails this tap, but the sweep carries on.
                  if (i_tap_readback != r_tap_val) begin
                     r_err  <= 1'b1;
                     r_pass <= 1'b0;
                  end else begin
                     r_pass <= 1'b1;
                  end
                  r_samp  <= 16'd0;
                  r_state <= ST_MEASURE;
               end else begin
                  r_settle <= r_settle - 16'd1;
               end
            end
            ST_MEASURE: begin
               if (i_sample_valid) begin
                  r_samp <= r_samp + 16'd1;
                  if (!i_sample_ok) begin
                     r_pass <= 1'b0;
                  end
                  if (r_samp == SAMP_LAST) begin
                     r_state <= ST_NEXT;
                  end
               end
            end
            ST_NEXT: begin
               if (r_tap == LAST_TAP) begin
                  r_state <= ST_CENTER;
               end else begin
                  r_tap   <= r_tap + 5'd1;
                  r_state <= ST_LOAD;
               end
            end
            ST_CENTER: begin
               if (w_best_len == 6'd0) begin
                  r_fail     <= 1'b1;
                  r_best_tap <= DEF_TAP;
               end else begin
                  r_best_tap <= w_center;
               end
               r_eye   <= w_best_len;
               r_state <= ST_APPLY;
            end
            ST_APPLY: begin
               r_tap_ld  <= 1'b1;
               r_tap_val <= r_best_tap;
               r_state   <= ST_DONE;
            end
            ST_DONE: begin
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_tap_ld    = r_tap_ld;
   assign o_tap_val   = r_tap_val;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_fail      = r_fail;
   assign o_err       = r_err;
   assign o_best_tap  = r_best_tap;
   assign o_eye_width = r_eye;

endmodule

// File: doc/idelay_tap_scan.md
Name: idelay_tap_scan

Overview:
- Control-side initiator for a 5-bit input delay line with load-style tap control and tap readback.
- Sweeps taps 0..31. At each tap it loads the tap, waits a settle time, then counts data-checker verdicts.
- It finds the longest contiguous passing window and loads the window centre.
- Sits between the host/local-bus register file and the per-lane delay element plus its pattern checker.

Parameters:
- SETTLE_CYCLES, 16, clk cycles after a tap load before samples are counted (min 2).
- SAMPLES, 64, number of sample_valid pulses evaluated per tap (1..65535).
- DEFAULT_TAP, 0, tap applied when no tap passes.

Ports:
- clk  in  1  single clock, shared with the delay element's control clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins a scan when idle.
- host_ld  in  1  one-cycle pulse; manual tap load when idle.
- host_val  in  5  manual tap value.
- tap_ld  out  1  one-cycle load strobe to the delay element.
- tap_val  out  5  tap value to the delay element; held between loads.
- tap_readback  in  5  current tap from the delay element.
- sample_valid  in  1  checker verdict strobe.
- sample_ok  in  1  checker verdict; received word matched, qualified by sample_valid.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final tap is applied.
- fail  out  1  sticky until next start; no passing tap found.
- err  out  1  sticky until next start; readback mismatch.
- best_tap  out  5  centre tap chosen.
- eye_width  out  6  length of the best window, 0..32.

Behaviour:
- Reset values (async assert, clocked release):
  - All outputs 0.
  - tap_val = DEFAULT_TAP.
  - FSM = IDLE.
  - Run trackers cleared.
- IDLE:
  - start=1: clear fail, err, trackers; tap=0; go to LOAD.
  - Otherwise host_ld=1: tap_ld=1 next cycle with tap_val=host_val; stay IDLE.
  - start wins if both arrive in the same cycle.
- LOAD:
  - tap_ld=1 for exactly one cycle with tap_val=tap.
  - Go to SETTLE with the settle counter = SETTLE_CYCLES.
- SETTLE:
  - Count down; sample_valid is ignored.
  - On the last cycle, compare tap_readback to tap_val.
  - Mismatch: set err; the tap counts as failing. The scan continues.
  - Then go to MEASURE with the sample counter = 0 and pass=1.
- MEASURE:
  - Each sample_valid increments the sample counter.
  - sample_valid with sample_ok=0 clears pass.
  - After the SAMPLES-th valid, go to NEXT.
  - There is no timeout; the host aborts via rst.
- NEXT (one cycle), run tracking:
  - pass=1: if cur_len==0 then cur_start=tap; cur_len+=1.
  - If the new cur_len > best_len (strictly), then best_start=cur_start and best_len=new cur_len. The earliest of equal-length windows wins.
  - pass=0: cur_len=0.
  - tap==31: go to CENTER. Otherwise tap+=1 and go to LOAD.
  - Taps are linear, with no wrap from 31 to 0.
- CENTER:
  - best_len==0: fail=1, best_tap=DEFAULT_TAP.
  - Otherwise best_tap = best_start + ((best_len-1)>>1), 5-bit. This is floor of the midpoint, so no overflow.
  - eye_width=best_len.
  - Go to APPLY.
- APPLY:
  - tap_ld=1 with tap_val=best_tap.
  - Go to DONE.
- DONE:
  - done=1 for one cycle, busy=0 that same cycle, then IDLE.
- During the scan:
  - start and host_ld are ignored while busy.
  - best_tap and eye_width keep their previous scan's values until CENTER.
- Reset mid-scan: immediate return to the reset state; tap_val=DEFAULT_TAP. No tap_ld is issued.
- Widths:
  - cur_len and best_len are 6-bit (32 must fit).
  - The sample counter is 16-bit.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, LOAD, SETTLE, MEASURE, NEXT, CENTER, APPLY, DONE).
  - TAP_W=5, NTAPS=32.
  - eye-width type (6-bit).
- One natural sub-module: idelay_run_tracker, which holds cur/best start/len, their update rule, and the centre computation.

Test Plan:
- All taps pass, SAMPLES=4: eye_width=32, best_tap=15, fail=0, done after 32 scan cycles. Final tap_ld shows tap_val=15.
- Pass only at taps 10..20: eye_width=11, best_tap=15. 33 tap_ld pulses total (32 scan + 1 apply).
- Two windows of equal length, taps 2..5 and 20..23: best_tap=3 and eye_width=4, proving the earliest window wins. A 5-tap window at 20..24 instead gives best_tap=22.
- No tap passes, DEFAULT_TAP=7: fail=1, best_tap=7, eye_width=0, final tap_val=7.
- Single sample_ok=0 at the last sample of tap 12, all other taps pass: best window 13..31 gives eye_width=19, best_tap=22.
- tap_readback stuck at 0:
  - err=1.
  - Tap 0 is judged only by samples.
  - All other taps fail.
  - Result: eye_width=1, best_tap=0.
- Reset and arbitration:
  - rst asserted during tap 9 of a scan: outputs return to reset values immediately. A fresh start then completes normally.
  - host_ld during busy has no effect.
